// File: rtl/tt_um_gate_sequencer_pkg.sv
// Shared definitions for the gate sequencer: gate codes, FSM states,
// per-gate truth tables and dwell defaults.
package tt_um_gate_sequencer_pkg;

  typedef enum logic [2:0] {
    GATE_AND     = 3'd0,
    GATE_OR      = 3'd1,
    GATE_NOTA    = 3'd2,
    GATE_NAND    = 3'd3,
    GATE_NOR     = 3'd4,
    GATE_XOR     = 3'd5,
    GATE_XNOR    = 3'd6,
    GATE_ILLEGAL = 3'd7
  } gate_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_APPLY = 3'd1,
    ST_CHECK = 3'd2,
    ST_NEXT  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Truth tables are indexed by {b, a}; bit 3 is the a=1, b=1 result.
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NOTA = 4'b0101;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;

  localparam logic [7:0][3:0] GATE_TT = {4'b0000, TT_XNOR, TT_XOR, TT_NOR,
                                         TT_NAND, TT_NOTA, TT_OR, TT_AND};

  localparam int DWELL_SHORT_DEF = 16;
  localparam int DWELL_LONG_DEF  = 65536;

endpackage

// File: rtl/tt_um_gate_sequencer_if.sv
// Pin bundle of the gate sequencer: driver side (master) and design side (slave).
interface tt_um_gate_sequencer_if;

  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
  modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);

endinterface

// File: rtl/tt_um_gate_sequencer_gate_eval.sv
// Combinational reference gate: expected output for the current gate and {b, a}.
module gate_eval
  import tt_um_gate_sequencer_pkg::*;
(
  input  logic [2:0] gate,
  input  logic       a,
  input  logic       b,
  output logic       expected
);

  assign expected = GATE_TT[gate][{b, a}];

endmodule

// File: rtl/tt_um_gate_sequencer.sv
// Gate tester: applies the four input vectors to an external gate, compares the
// synchronized response with the selected gate's truth table and reports pass/err.
module tt_um_gate_sequencer
  import tt_um_gate_sequencer_pkg::*;
#(
  parameter int DWELL_SHORT = DWELL_SHORT_DEF,
  parameter int DWELL_LONG  = DWELL_LONG_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int CW = $clog2(DWELL_LONG + 1);
  localparam logic [CW-1:0] SHORT_LAST = CW'(DWELL_SHORT - 1);
  localparam logic [CW-1:0] LONG_LAST  = CW'(DWELL_LONG - 1);

  state_e        state_q, state_d;
  logic [2:0]    meta_q, meta_d;
  logic [2:0]    sync_q, sync_d;
  logic [1:0]    prev_q, prev_d;
  logic [1:0]    vec_q, vec_d;
  logic [2:0]    gate_q, gate_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          sweep_q, sweep_d;
  logic          stepm_q, stepm_d;
  logic          long_q, long_d;

  logic start_edge, step_edge, dwell_hit, illegal_start;
  logic expected, busy, done, unused_pins;

  // Synchronizer lanes: 0 = start, 1 = step, 2 = observed gate response.
  assign start_edge    = sync_q[0] & ~prev_q[0];
  assign step_edge     = sync_q[1] & ~prev_q[1] & stepm_q;
  assign dwell_hit     = cnt_q == (long_q ? LONG_LAST : SHORT_LAST);
  assign illegal_start = ~ui_in[4] & (ui_in[2:0] == GATE_ILLEGAL);
  assign unused_pins   = ^uio_in[7:1];

  gate_eval u_gate_eval (
    .gate     (gate_q),
    .a        (vec_q[0]),
    .b        (vec_q[1]),
    .expected (expected)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      meta_q  <= '0;
      sync_q  <= '0;
      prev_q  <= '0;
      vec_q   <= '0;
      gate_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      sweep_q <= 1'b0;
      stepm_q <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      vec_q   <= vec_d;
      gate_q  <= gate_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      sweep_q <= sweep_d;
      stepm_q <= stepm_d;
      long_q  <= long_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (ena) begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_edge) state_d = illegal_start ? ST_DONE : ST_APPLY;
        end
        ST_APPLY: begin
          if (stepm_q ? step_edge : dwell_hit) state_d = ST_CHECK;
        end
        ST_CHECK: state_d = ST_NEXT;
        ST_NEXT: begin
          if (vec_q != 2'd3 || (sweep_q && gate_q < GATE_XNOR)) state_d = ST_APPLY;
          else                                                   state_d = ST_DONE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath updates; everything holds while ena is low.
  always_comb begin
    meta_d  = meta_q;
    sync_d  = sync_q;
    prev_d  = prev_q;
    vec_d   = vec_q;
    gate_d  = gate_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    sweep_d = sweep_q;
    stepm_d = stepm_q;
    long_d  = long_q;
    if (ena) begin
      meta_d = {uio_in[0], ui_in[5], ui_in[3]};
      sync_d = meta_q;
      prev_d = sync_q[1:0];
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_edge) begin
            vec_d   = 2'd0;
            cnt_d   = '0;
            err_d   = illegal_start;
            gate_d  = ui_in[4] ? GATE_AND : ui_in[2:0];
            sweep_d = ui_in[4];
            stepm_d = ui_in[6];
            long_d  = ui_in[7];
          end
        end
        ST_APPLY: begin
          if (!stepm_q) cnt_d = dwell_hit ? '0 : cnt_q + 1'b1;
        end
        ST_CHECK: begin
          if (sync_q[2] != expected) err_d = 1'b1;
        end
        ST_NEXT: begin
          if (vec_q != 2'd3) begin
            vec_d = vec_q + 2'd1;
          end else if (sweep_q && gate_q < GATE_XNOR) begin
            gate_d = gate_q + 3'd1;
            vec_d  = 2'd0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy    = (state_q == ST_APPLY) || (state_q == ST_CHECK) || (state_q == ST_NEXT);
    done    = (state_q == ST_DONE);
    uo_out  = {done & ~err_q, sync_q[2], err_q, done, busy, expected, vec_q[1], vec_q[0]};
    uio_out = {3'b000, gate_q, vec_q[1], vec_q[0]};
    uio_oe  = 8'b0001_1111;
  end

endmodule

// File: tb/tb_tt_um_gate_sequencer.sv
// Randomized bench for the gate sequencer against a behavioural run model.
module tb_tt_um_gate_sequencer;

  localparam int DS = 16;
  localparam int DL = 40;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] rtt_q;
  logic [6:0] junk;
  int         errors = 0;
  int         checks = 0;

  tt_um_gate_sequencer_if bus ();

  // External gate model: response table indexed by the applied {b, a}.
  assign bus.uio_in = {junk, rtt_q[bus.uio_out[1:0]]};

  tt_um_gate_sequencer #(.DWELL_SHORT(DS), .DWELL_LONG(DL)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (bus.ena),
    .ui_in   (bus.ui_in),
    .uo_out  (bus.uo_out),
    .uio_in  (bus.uio_in),
    .uio_out (bus.uio_out),
    .uio_oe  (bus.uio_oe)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit gate_fn(input int g, input int v);
    bit a, b;
    a = v[0];
    b = v[1];
    case (g)
      0:       return a & b;
      1:       return a | b;
      2:       return !a;
      3:       return !(a & b);
      4:       return !(a | b);
      5:       return a ^ b;
      6:       return !(a ^ b);
      default: return 1'b0;
    endcase
  endfunction

  task automatic do_run(input int sel, input bit sweep, input bit lng, input bit stepm,
                        input logic [3:0] rtt, input bit noise, input int freeze_at,
                        input bit poke_start, input bit rst_mid);
    int exp_pairs[$];
    int obs_pairs[$];
    int obs_exp[$];
    int n, dwell, exp_len, exp_err_idx, obs_err_idx, cyc, bound, last_pair, cur, m;
    int busy_seen, done_seen;
    bit illegal, is_done;

    illegal = (sel == 7) && !sweep;
    for (int g = 0; g < 7; g++)
      if (sweep || g == sel)
        for (int v = 0; v < 4; v++) exp_pairs.push_back(g * 4 + v);
    n = exp_pairs.size();
    dwell = lng ? DL : DS;
    exp_len = n * (dwell + 2) + ((freeze_at >= 0) ? 10 : 0);
    exp_err_idx = -1;
    for (int i = 0; i < n; i++)
      if (exp_err_idx < 0 && gate_fn(exp_pairs[i] / 4, exp_pairs[i] % 4) != rtt[2'(exp_pairs[i] % 4)])
        exp_err_idx = i;

    rtt_q = rtt;
    bus.ui_in = {lng, stepm, 1'b0, sweep, 1'b1, 3'(sel)};
    tick();
    tick();
    check_eq("busy_early", int'(bus.uo_out[3]), 0);
    tick();
    if (illegal) begin
      check_eq("illegal_busy", int'(bus.uo_out[3]), 0);
      check_eq("illegal_done", int'(bus.uo_out[4]), 1);
      check_eq("illegal_err", int'(bus.uo_out[5]), 1);
      check_eq("illegal_pass", int'(bus.uo_out[7]), 0);
      bus.ui_in[3] = 1'b0;
      busy_seen = 0;
      repeat (4) begin
        tick();
        busy_seen += int'(bus.uo_out[3]);
      end
      check_eq("illegal_busy_later", busy_seen, 0);
      $display("run sel=%0d sweep=%0d illegal: done=%0d err=%0d", sel, sweep, bus.uo_out[4], bus.uo_out[5]);
      return;
    end
    check_eq("busy_rise", int'(bus.uo_out[3]), 1);
    last_pair = int'(bus.uio_out[4:0]);
    obs_pairs.push_back(last_pair);
    obs_exp.push_back(int'(bus.uo_out[2]));
    obs_err_idx = -1;
    bound = stepm ? 60 + n * 12 + 40 : exp_len + 40;
    cyc = 0;
    is_done = 1'b0;
    while (!is_done && cyc < bound) begin
      if (cyc == 1) bus.ui_in[3] = 1'b0;
      if (poke_start) bus.ui_in[3] = (cyc >= 20 && cyc < 24);
      if (noise && !stepm) begin
        bus.ui_in[5] = 1'($urandom);
        if (cyc == 5) {bus.ui_in[7:6], bus.ui_in[4], bus.ui_in[2:0]} = 6'($urandom);
      end
      if (stepm) bus.ui_in[5] = (cyc >= 60 && cyc < 60 + n * 12 && ((cyc - 60) % 12) < 4);
      bus.ena = !(freeze_at >= 0 && cyc >= freeze_at && cyc < freeze_at + 10);
      tick();
      cyc++;
      cur = int'(bus.uio_out[4:0]);
      if (bus.uo_out[3] && cur != last_pair) begin
        obs_pairs.push_back(cur);
        obs_exp.push_back(int'(bus.uo_out[2]));
        last_pair = cur;
      end
      if (obs_err_idx < 0 && bus.uo_out[5]) obs_err_idx = obs_pairs.size() - 1;
      if (stepm && cyc == 59) begin
        check_eq("step_hold_vectors", obs_pairs.size(), 1);
        check_eq("step_hold_busy", int'(bus.uo_out[3]), 1);
      end
      if (rst_mid && obs_pairs.size() == 3) begin
        rst_n = 1'b0;
        #1;
        check_eq("rst_uo_out", int'(bus.uo_out), 0);
        check_eq("rst_uio_out", int'(bus.uio_out), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        busy_seen = 0;
        done_seen = 0;
        repeat (20) begin
          tick();
          busy_seen += int'(bus.uo_out[3]);
          done_seen += int'(bus.uo_out[4]) + int'(bus.uo_out[7]);
        end
        check_eq("rst_stays_idle", busy_seen, 0);
        check_eq("rst_no_done", done_seen, 0);
        bus.ena = 1'b1;
        $display("run sel=%0d reset at vector 2: idle_busy=%0d done_pulses=%0d", sel, busy_seen, done_seen);
        return;
      end
      is_done = bus.uo_out[4];
    end
    bus.ena = 1'b1;
    bus.ui_in[5] = 1'b0;

    check_eq("done", int'(is_done), 1);
    if (!stepm)
      check_eq("run_length", (cyc - exp_len >= -2 && cyc - exp_len <= 2) ? exp_len : cyc, exp_len);
    check_eq("err", int'(bus.uo_out[5]), (exp_err_idx >= 0) ? 1 : 0);
    check_eq("pass", int'(bus.uo_out[7]), (exp_err_idx >= 0) ? 0 : 1);
    check_eq("busy_after", int'(bus.uo_out[3]), 0);
    check_eq("vector_count", obs_pairs.size(), n);
    check_eq("first_err_vector", obs_err_idx, exp_err_idx);
    m = (obs_pairs.size() < n) ? obs_pairs.size() : n;
    for (int i = 0; i < m; i++) begin
      check_eq($sformatf("pair%0d", i), obs_pairs[i], exp_pairs[i]);
      check_eq($sformatf("expected%0d", i), obs_exp[i], int'(gate_fn(exp_pairs[i] / 4, exp_pairs[i] % 4)));
    end
    $display("run sel=%0d sweep=%0d long=%0d step=%0d resp=%b freeze=%0d: vectors=%0d cycles=%0d err=%0d pass=%0d",
             sel, sweep, lng, stepm, rtt, freeze_at, obs_pairs.size(), cyc, bus.uo_out[5], bus.uo_out[7]);
    repeat (3) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sel;
    bit sweep, lng, stepm, noise;
    int freeze_at;
    logic [3:0] rtt;

    rst_n = 1'b0;
    bus.ena = 1'b1;
    bus.ui_in = 8'h00;
    junk = 7'($urandom);
    rtt_q = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_uo_out", int'(bus.uo_out), 0);
    check_eq("reset_uio_out", int'(bus.uio_out), 0);
    check_eq("reset_uio_oe", int'(bus.uio_oe), 8'h1F);
    rst_n = 1'b1;
    repeat (2) tick();

    do_run(5, 1'b0, 1'b0, 1'b0, 4'b0110, 1'b0, -1, 1'b0, 1'b0);
    do_run(5, 1'b1, 1'b0, 1'b0, 4'b0110, 1'b0, -1, 1'b0, 1'b0);
    do_run(0, 1'b0, 1'b0, 1'b1, 4'b1000, 1'b0, -1, 1'b0, 1'b0);
    do_run(7, 1'b0, 1'b0, 1'b0, 4'b0110, 1'b0, -1, 1'b0, 1'b0);
    do_run(3, 1'b0, 1'b0, 1'b0, 4'b0110, 1'b0, -1, 1'b0, 1'b1);
    do_run(1, 1'b0, 1'b1, 1'b0, 4'b1110, 1'b0, 10, 1'b1, 1'b0);

    for (int r = 0; r < 12; r++) begin
      sel   = $urandom_range(0, 7);
      sweep = ($urandom_range(0, 3) == 0);
      lng   = 1'($urandom);
      stepm = !sweep && ($urandom_range(0, 4) == 0);
      noise = !stepm && 1'($urandom);
      freeze_at = (!stepm && $urandom_range(0, 2) == 0) ? $urandom_range(3, 20) : -1;
      if (1'($urandom)) begin
        for (int v = 0; v < 4; v++) rtt[v] = gate_fn(sel, v);
      end else begin
        rtt = 4'($urandom);
      end
      junk = 7'($urandom);
      do_run(sel, sweep, lng, stepm, rtt, noise, freeze_at, 1'($urandom), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tt_um_gate_sequencer.md
TT_UM_GATE_SEQUENCER -- requirements
Module: tt_um_gate_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, sole clock domain.
REQ-002 SHALL have ports: rst_n  in  1  reset; asynchronous assert, active-low.
REQ-003 SHALL have ports: ena  in  1  enable; low = freeze all state, outputs held.
REQ-004 SHALL have ports: ui_in  in  8  [2:0] gate sel, [3] start, [4] sweep_all, [5] step, [6] step_mode, [7] dwell_sel.
REQ-005 SHALL have ports: uo_out  out  8  [0] a, [1] b, [2] expected, [3] busy, [4] done, [5] err, [6] observed, [7] pass.
REQ-006 SHALL have ports: uio_in  in  8  [0] external gate response; [7:1] ignored.
REQ-007 SHALL have ports: uio_out  out  8  [0] a, [1] b, [4:2] current gate index, [7:5] 0.
REQ-008 SHALL have ports: uio_oe  out  8  constant 8'b0001_1111.
REQ-009 SHALL have parameters: DWELL_SHORT, default 16, cycles per vector when dwell_sel=0.
REQ-010 SHALL have parameters: DWELL_LONG, default 65536, cycles per vector when dwell_sel=1.

Function
REQ-011 Gate codes SHALL be 0 AND, 1 OR, 2 NOT A, 3 NAND, 4 NOR, 5 XOR, 6 XNOR; code 7 is illegal.
REQ-012 ui_in[3], ui_in[5] and uio_in[0] SHALL pass through 2-flop synchronizers; start and step act on synchronized rising edges only.
REQ-013 FSM states SHALL be IDLE, APPLY, CHECK, NEXT, DONE.
REQ-014 IDLE SHALL move to APPLY on a start edge: vector=00, err cleared, done cleared, gate = sweep_all ? 0 : sel.
REQ-015 Start with sel=7 and sweep_all=0 SHALL go directly to DONE with err=1.
REQ-016 busy SHALL be high in APPLY, CHECK and NEXT, and SHALL rise on the 3rd rising clk after ui_in[3] goes high.
REQ-017 APPLY timed mode: SHALL drive {b,a}=vector and count the dwell (DWELL_SHORT or DWELL_LONG, latched at start), then enter CHECK.
REQ-018 APPLY step mode: SHALL wait indefinitely for a step edge, then enter CHECK.
REQ-019 CHECK (1 cycle): SHALL compare synchronized observed against expected and set sticky err on mismatch.
REQ-020 NEXT: vector<3 SHALL increment vector and return to APPLY.
REQ-021 NEXT: vector=3 with sweep_all=1 and gate<6 SHALL increment gate, set vector=00, return to APPLY.
REQ-022 NEXT: all other cases SHALL go to DONE.
REQ-023 DONE SHALL hold done=1; pass = done & ~err; a start edge SHALL restart as in REQ-014.
REQ-024 Start edges SHALL be ignored while busy; step edges SHALL be ignored outside APPLY or when step_mode=0.
REQ-025 sel, sweep_all and step_mode SHALL be latched at start; changes mid-run have no effect.
REQ-026 expected SHALL be the combinational gate result of the current gate and {b,a}.
REQ-027 A full sweep SHALL check 28 vectors; a timed run SHALL take 28*(dwell+2) cycles ±2.
REQ-028 ena=0 SHALL freeze the FSM, counters and synchronizers; dwell timing resumes without loss.

Reset
REQ-029 rst_n low SHALL asynchronously force IDLE, vector=0, gate=0, dwell counter=0, synchronizers=0, and all uo_out bits and uio_out bits 0.
REQ-030 Reset asserted mid-run SHALL abort the run with no done or pass pulse; release SHALL require a fresh start edge.

Structure
REQ-031 A shared package SHALL hold the gate-code enum, the FSM state enum, the 4-bit per-gate truth-table constants, and the dwell defaults.
REQ-032 Sub-module gate_eval SHALL be instantiated: combinational (gate, a, b) -> expected, looking up the package truth tables.

Verification
REQ-033 Loopback (uio_out driven as the XOR of uio_out[1:0] into uio_in[0]), sel=5, sweep_all=0, dwell_sel=0, start -> 4 vectors 00,01,10,11; done=1, err=0, pass=1 at cycle ~75.
REQ-034 Same loopback, sweep_all=1 -> gate index walks 0..6; err=1 at the first non-XOR mismatch (AND, vector 01); pass=0.
REQ-035 step_mode=1, sel=0, uio_in[0]=a&b model -> no advance without step; 4 step pulses -> done=1, pass=1.
REQ-036 sel=7, sweep_all=0, start -> DONE within 4 cycles, err=1, busy never high.
REQ-037 Run in progress, rst_n low for 1 cycle at vector 2 -> all outputs 0 immediately; IDLE after release; done stays 0.
REQ-038 ena=0 for 10 cycles mid-dwell -> total run length grows by exactly 10 cycles; start edge while busy is ignored.
